// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: upstream, flush and execute-side handshake for the decode slot.
interface alu_decode_stage_if #(
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic             o_id_ready;
    logic [31:0]      i_instr;
    logic [31:0]      i_pc;
    logic [31:0]      i_rs1_data;
    logic [31:0]      i_rs2_data;
    logic             i_flush;
    logic             i_ex_ready;
    logic             o_valid;
    logic [3:0]       o_alu_op;
    logic [31:0]      o_op_a;
    logic [31:0]      o_op_b;
    logic [31:0]      o_pc;
    logic [4:0]       o_rd;
    logic             o_rd_we;
    logic             o_illegal;
    logic [CNT_W-1:0] o_issue_cnt;

    modport master (
        output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ex_ready,
        input  o_id_ready, o_valid, o_alu_op, o_op_a, o_op_b, o_pc, o_rd, o_rd_we,
               o_illegal, o_issue_cnt
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ex_ready,
        output o_id_ready, o_valid, o_alu_op, o_op_a, o_op_b, o_pc, o_rd, o_rd_we,
               o_illegal, o_issue_cnt
    );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU op + operands
// and holds the result in a single registered slot toward execute.
module alu_decode_stage #(
    parameter int CNT_W = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    alu_decode_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_SLT = 4'h2, OP_SLTU = 4'h3,
                           OP_XOR = 4'h4, OP_OR = 4'h5, OP_AND = 4'h6, OP_SLL = 4'h7,
                           OP_SRL = 4'h8, OP_SRA = 4'h9, OP_LUI = 4'hA;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011,
                           OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;

    typedef enum logic {EMPTY, FULL} slot_e;

    slot_e            state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d, pc_q, pc_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_we_q, rd_we_d, illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] upper;
    logic [3:0]  f3_op, dec_op;
    logic [31:0] dec_a, dec_b;
    logic        dec_legal, is_shift, accept;

    assign opc   = bus.i_instr[6:0];
    assign f3    = bus.i_instr[14:12];
    assign f7    = bus.i_instr[31:25];
    assign rd    = bus.i_instr[11:7];
    assign upper = {bus.i_instr[31:12], 12'h0};

    always_comb begin
        f3_op = f3 == 3'b000 ? OP_ADD :
                f3 == 3'b001 ? OP_SLL :
                f3 == 3'b010 ? OP_SLT :
                f3 == 3'b011 ? OP_SLTU :
                f3 == 3'b100 ? OP_XOR :
                f3 == 3'b101 ? OP_SRL :
                f3 == 3'b110 ? OP_OR : OP_AND;
        is_shift  = f3 == 3'b001 || f3 == 3'b101;
        dec_op    = f3_op;
        dec_a     = bus.i_rs1_data;
        dec_b     = bus.i_rs2_data;
        dec_legal = 1'b1;
        case (opc)
            OPC_OP: begin
                // funct7 0x20 is only meaningful for SUB and SRA
                dec_legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                dec_op    = f7 == 7'h20 ? (f3 == 3'b000 ? OP_SUB : OP_SRA) : f3_op;
            end
            OPC_IMM: begin
                dec_b     = is_shift ? {27'h0, bus.i_instr[24:20]} : {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
                dec_legal = !is_shift || f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20);
                dec_op    = (is_shift && f3 == 3'b101 && f7 == 7'h20) ? OP_SRA : f3_op;
            end
            OPC_LUI: begin
                dec_op = OP_LUI;
                dec_a  = 32'h0;
                dec_b  = upper;
            end
            OPC_AUIPC: begin
                dec_op = OP_ADD;
                dec_a  = bus.i_pc;
                dec_b  = upper;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_op = OP_ADD;
            dec_a  = 32'h0;
            dec_b  = 32'h0;
        end
    end

    assign bus.o_id_ready = (state_q == EMPTY || bus.i_ex_ready) && !bus.i_flush;
    assign accept         = bus.i_valid && bus.o_id_ready;

    // Flush wins over accept and drain; a stalled FULL slot keeps its fields.
    always_comb begin
        state_d   = bus.i_flush ? EMPTY : accept ? FULL : bus.i_ex_ready ? EMPTY : state_q;
        op_d      = accept ? dec_op : op_q;
        a_d       = accept ? dec_a : a_q;
        b_d       = accept ? dec_b : b_q;
        pc_d      = accept ? bus.i_pc : pc_q;
        rd_d      = accept ? rd : rd_q;
        rd_we_d   = accept ? dec_legal && rd != 5'd0 : rd_we_q;
        illegal_d = accept ? !dec_legal : illegal_q;
        cnt_d     = cnt_q + CNT_W'(state_q == FULL && bus.i_ex_ready && !bus.i_flush);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= EMPTY;
            op_q      <= 4'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            pc_q      <= 32'h0;
            rd_q      <= 5'h0;
            rd_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.o_valid     = state_q == FULL;
    assign bus.o_alu_op    = op_q;
    assign bus.o_op_a      = a_q;
    assign bus.o_op_b      = b_q;
    assign bus.o_pc        = pc_q;
    assign bus.o_rd        = rd_q;
    assign bus.o_rd_we     = rd_we_q;
    assign bus.o_illegal   = illegal_q;
    assign bus.o_issue_cnt = cnt_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed vectors with hand-computed decode results,
// backpressure, flush, counter wrap (4-bit counter) and mid-stall reset.
module tb_alu_decode_stage;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_decode_stage_if #(.CNT_W(CW)) bus ();

    alu_decode_stage #(.CNT_W(CW)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc);
        bus.i_valid    = v;
        bus.i_instr    = instr;
        bus.i_rs1_data = rs1;
        bus.i_rs2_data = rs2;
        bus.i_pc       = pc;
    endtask

    task automatic slot(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic we,
                        input logic ill, input logic [CW-1:0] cnt);
        check({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, ".op"}, 32'(bus.o_alu_op), 32'(op));
        check({tag, ".a"}, bus.o_op_a, a);
        check({tag, ".b"}, bus.o_op_b, b);
        check({tag, ".rd"}, 32'(bus.o_rd), 32'(rd));
        check({tag, ".rd_we"}, 32'(bus.o_rd_we), 32'(we));
        check({tag, ".illegal"}, 32'(bus.o_illegal), 32'(ill));
        check({tag, ".cnt"}, 32'(bus.o_issue_cnt), 32'(cnt));
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, ".op"}, 32'(bus.o_alu_op), 32'd0);
        check({tag, ".a"}, bus.o_op_a, 32'd0);
        check({tag, ".b"}, bus.o_op_b, 32'd0);
        check({tag, ".pc"}, bus.o_pc, 32'd0);
        check({tag, ".rd"}, 32'(bus.o_rd), 32'd0);
        check({tag, ".rd_we"}, 32'(bus.o_rd_we), 32'd0);
        check({tag, ".illegal"}, 32'(bus.o_illegal), 32'd0);
        check({tag, ".cnt"}, 32'(bus.o_issue_cnt), 32'd0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.i_flush    = 1'b0;
        bus.i_ex_ready = 1'b1;
        #1;
        all_zero("reset");
        #11 rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(bus.o_id_ready), 32'd1);

        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'h0);
        tick();
        slot("add", 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 4'd0);
        check("add.pc", bus.o_pc, 32'h0);
        drive(1'b1, 32'h40435293, 32'h80000000, 32'h0, 32'h4);
        tick();
        slot("srai", 4'h9, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0, 4'd1);
        check("srai.pc", bus.o_pc, 32'h4);
        drive(1'b1, 32'h00435293, 32'h80000000, 32'h0, 32'h8);
        tick();
        slot("srli", 4'h8, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0, 4'd2);
        drive(1'b1, 32'h402081B3, 32'd5, 32'd7, 32'hC);
        tick();
        slot("sub", 4'h1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 4'd3);
        drive(1'b1, 32'hFFF08093, 32'd9, 32'd7, 32'h10);
        tick();
        slot("addi_neg", 4'h0, 32'd9, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 4'd4);
        drive(1'b1, 32'h123450B7, 32'hDEADBEEF, 32'h1, 32'h14);
        tick();
        slot("lui", 4'hA, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0, 4'd5);
        drive(1'b1, 32'h00001117, 32'hDEADBEEF, 32'h1, 32'h100);
        tick();
        slot("auipc", 4'h0, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0, 4'd6);
        drive(1'b1, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h104);
        tick();
        slot("illegal_opc", 4'h0, 32'h0, 32'h0, 5'd31, 1'b0, 1'b1, 4'd7);
        drive(1'b1, 32'h022081B3, 32'd5, 32'd7, 32'h108);
        tick();
        slot("illegal_f7", 4'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 4'd8);
        drive(1'b1, 32'h40409093, 32'd5, 32'd7, 32'h10C);
        tick();
        slot("illegal_slli", 4'h0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1, 4'd9);
        drive(1'b1, 32'h00208033, 32'd5, 32'd7, 32'h110);
        tick();
        slot("add_x0", 4'h0, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 4'd10);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("drain.valid", 32'(bus.o_valid), 32'd0);
        check("drain.cnt", 32'(bus.o_issue_cnt), 32'd11);

        bus.i_ex_ready = 1'b0;
        drive(1'b1, 32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h200);
        tick();
        slot("bp_first", 4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b1, 1'b0, 4'd11);
        drive(1'b1, 32'h0020E233, 32'h11111111, 32'h0FF00FF0, 32'h204);
        #1;
        check("bp.ready_low", 32'(bus.o_id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            slot("bp_hold", 4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b1, 1'b0, 4'd11);
            check("bp_hold.pc", bus.o_pc, 32'h200);
        end
        bus.i_ex_ready = 1'b1;
        #1;
        check("bp.ready_high", 32'(bus.o_id_ready), 32'd1);
        tick();
        slot("bp_second", 4'h5, 32'h11111111, 32'h0FF00FF0, 5'd4, 1'b1, 1'b0, 4'd12);
        check("bp_second.pc", bus.o_pc, 32'h204);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("bp_done.valid", 32'(bus.o_valid), 32'd0);
        check("bp_done.cnt", 32'(bus.o_issue_cnt), 32'd13);

        drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 32'h300);
        tick();
        check("stream1.cnt", 32'(bus.o_issue_cnt), 32'd13);
        tick();
        check("stream2.cnt", 32'(bus.o_issue_cnt), 32'd14);
        tick();
        check("stream3.cnt", 32'(bus.o_issue_cnt), 32'd15);
        check("stream3.valid", 32'(bus.o_valid), 32'd1);

        bus.i_flush = 1'b1;
        drive(1'b1, 32'h123450B7, 32'h0, 32'h0, 32'h400);
        #1;
        check("flush.ready_low", 32'(bus.o_id_ready), 32'd0);
        tick();
        check("flush.valid", 32'(bus.o_valid), 32'd0);
        check("flush.cnt", 32'(bus.o_issue_cnt), 32'd15);
        check("flush.op_not_lui", 32'(bus.o_alu_op), 32'd0);
        bus.i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("post_flush.cnt", 32'(bus.o_issue_cnt), 32'd15);
        drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 32'h500);
        tick();
        check("wrap_pre.cnt", 32'(bus.o_issue_cnt), 32'd15);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("wrap.cnt", 32'(bus.o_issue_cnt), 32'd0);

        bus.i_ex_ready = 1'b0;
        drive(1'b1, 32'h123450B7, 32'h0, 32'h0, 32'h600);
        tick();
        slot("stall_lui", 4'hA, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0, 4'd0);
        tick();
        #3 rst_n = 1'b0;
        #1;
        all_zero("mid_reset");
        #1 rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("mid_reset.ready", 32'(bus.o_id_ready), 32'd1);
        tick();
        check("after_reset.valid", 32'(bus.o_valid), 32'd0);
        check("after_reset.cnt", 32'(bus.o_issue_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode/issue stage that sits directly upstream of the RV32I ALU. It accepts one fetched instruction with its PC and register-file read data, and decodes OP, OP-IMM, LUI and AUIPC into the 4-bit ALU operation codes and the two 32-bit ALU operands. The results are held in a registered pipeline slot with a valid/ready handshake toward the execute stage. The block also flags unsupported encodings, supports a pipeline flush, and counts issued instructions.

## Interface
- CNT_W, 16, width of the issued-instruction counter
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream has an instruction
- o_id_ready  out  1  stage can accept; combinational: (!o_valid || i_ex_ready) && !i_flush
- i_instr  in  32  instruction word
- i_pc  in  32  instruction address
- i_rs1_data  in  32  register-file data for instr[19:15]
- i_rs2_data  in  32  register-file data for instr[24:20]
- i_flush  in  1  discard the held slot and block acceptance this cycle
- i_ex_ready  in  1  execute stage accepts the slot
- o_valid  out  1  slot holds a decoded instruction
- o_alu_op  out  4  ALU code: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, LUI=A
- o_op_a  out  32  ALU operand A
- o_op_b  out  32  ALU operand B
- o_pc  out  32  PC of the held instruction
- o_rd  out  5  destination register instr[11:7]
- o_rd_we  out  1  write-back enable
- o_illegal  out  1  held instruction is not decodable by this stage
- o_issue_cnt  out  CNT_W  count of execute-side handshakes

## Operation
- Accept occurs when i_valid && o_id_ready. The slot captures the decode of i_instr on the next edge.
- OP (opcode 0110011):
  - funct3 000 → ADD (funct7 0x00) or SUB (funct7 0x20).
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 110 → OR; 111 → AND.
  - 101 → SRL (funct7 0x00) or SRA (funct7 0x20).
  - Any other funct7 value is illegal.
  - a = rs1_data, b = rs2_data.
- OP-IMM (0010011):
  - Same funct3 map; there is no SUB.
  - a = rs1_data. b = sign-extended instr[31:20].
  - Shifts use b = {27'h0, instr[24:20]}.
  - Shift funct7 rules: SLLI needs funct7 0x00; SRLI needs 0x00; SRAI needs 0x20. Anything else is illegal.
- LUI (0110111): op LUI, a = 0, b = {instr[31:12], 12'h0}.
- AUIPC (0010111): op ADD, a = i_pc, b = {instr[31:12], 12'h0}.
- Any other opcode, or an illegal funct7: o_illegal=1, o_alu_op=ADD, a=b=0, o_rd_we=0. The slot still becomes valid so the exception reaches execute.
- o_rd_we = legal && (rd != 0).
- All slot fields are registered. Nothing on the output side is combinational from i_instr.
- Slot state:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept while i_ex_ready=1 (back-to-back).
  - FULL → EMPTY on i_ex_ready without accept.
  - FULL stays FULL, with fields frozen, while i_ex_ready=0.
- Flush has priority over every other event. o_valid goes 0 on the next edge, no accept occurs, and o_issue_cnt does not increment for the discarded slot.
- o_issue_cnt increments on o_valid && i_ex_ready && !i_flush. It wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: 1 cycle from accept to o_valid.
- Throughput: 1 instruction per cycle while i_ex_ready=1.
- Reset (asynchronous on i_rst_n low):
  - o_valid, o_alu_op, o_op_a, o_op_b, o_pc, o_rd, o_rd_we, o_illegal and o_issue_cnt are all 0 immediately.
  - o_id_ready = 1 once reset is released.
- Reset mid-operation drops the held slot with no partial issue.
- Operands are sampled at the accept edge only. Later changes on i_rs*_data do not affect a held slot.
- Data fields are don't-care when o_valid=0, except for the reset values above.

## Test plan
- ADD: i_instr=0x002081B3, rs1=5, rs2=7, i_ex_ready=1 → next cycle o_valid=1, op=0, a=5, b=7, rd=3, rd_we=1, issue_cnt 0→1.
- SRAI: i_instr=0x40435293, rs1=0x80000000 → op=9, a=0x80000000, b=4, rd=5. Also 0x00435293 (SRLI) → op=8.
- LUI/AUIPC:
  - 0x123450B7 → op=A, a=0, b=0x12345000, rd=1.
  - 0x00001117 with pc=0x100 → op=0, a=0x100, b=0x1000.
- Backpressure: issue two instructions with i_ex_ready=0 for 3 cycles → first slot held unchanged and o_id_ready=0. When ready rises, the first issues and the second is accepted the same cycle, then appears next cycle. issue_cnt counts 2 total.
- Illegal/flush:
  - 0xFFFFFFFF → o_illegal=1, rd_we=0, op=0.
  - i_flush while FULL and i_valid=1 → o_valid=0 next cycle, nothing accepted, count unchanged.
  - i_rst_n low mid-stall → all outputs 0 immediately.
